// File: rtl/data_mem_arbiter_if.sv
// Core-array / data-RAM bundle for the shared data memory arbiter.
// slave is the arbiter's view; master is the cores-plus-RAM side.
interface data_mem_arbiter_if #(
    parameter int core_count = 2,
    parameter int addr_width = 12,
    parameter int reg_width  = 12,
    parameter int cnt_width  = 16
) ();
    logic [core_count-1:0]            req;
    logic [core_count-1:0]            lock;
    logic [core_count-1:0]            wr;
    logic [addr_width*core_count-1:0] addr_in;
    logic [reg_width*core_count-1:0]  wdata_in;
    logic [core_count-1:0]            gnt;
    logic [core_count-1:0]            rvalid;
    logic [reg_width-1:0]             rdata;
    logic [addr_width-1:0]            mem_addr;
    logic [reg_width-1:0]             mem_wdata;
    logic                             mem_wren;
    logic [reg_width-1:0]             mem_q;
    logic [cnt_width-1:0]             conflict_count;

    modport slave (
        input  req, lock, wr, addr_in, wdata_in, mem_q,
        output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren,
        output conflict_count
    );

    modport master (
        output req, lock, wr, addr_in, wdata_in, mem_q,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren,
        input  conflict_count
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM among cores,
// with bounded lock bursts and a saturating contention counter.
module data_mem_arbiter #(
    parameter int core_count = 2,
    parameter int addr_width = 12,
    parameter int reg_width  = 12,
    parameter int max_burst  = 4,
    parameter int cnt_width  = 16
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    localparam int PW = $clog2(core_count);
    localparam int BW = (max_burst > 1) ? $clog2(max_burst) : 1;

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic [core_count-1:0] rd_pend_q, rd_pend_d;
    logic [cnt_width-1:0]  conflict_q, conflict_d;

    logic [core_count-1:0] gnt;
    logic [PW-1:0]         win;
    logic [PW-1:0]         nxt;
    logic                  any;
    logic                  many;
    logic [addr_width-1:0] mem_addr;
    logic [reg_width-1:0]  mem_wdata;
    int                    idx;
    int                    nreq;

    // Scan from ptr upward; descending loop leaves the nearest requester.
    always_comb begin
        gnt  = '0;
        win  = ptr_q;
        any  = 1'b0;
        idx  = 0;
        nreq = 0;
        for (int i = core_count - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= core_count) idx = idx - core_count;
            if (bus.req[PW'(idx)]) begin
                win = PW'(idx);
                any = 1'b1;
            end
        end
        for (int j = 0; j < core_count; j++) begin
            if (bus.req[j]) nreq = nreq + 1;
        end
        if (reset) any = 1'b0;
        if (any) gnt[win] = 1'b1;
        many = (nreq >= 2);
        nxt  = (int'(win) == core_count - 1) ? '0 : win + 1'b1;
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        for (int j = 0; j < core_count; j++) begin
            if (PW'(j) == win) begin
                mem_addr  = bus.addr_in[j*addr_width +: addr_width];
                mem_wdata = bus.wdata_in[j*reg_width +: reg_width];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        rd_pend_d   = gnt & ~bus.wr;
        conflict_d  = conflict_q;
        if (many && conflict_q != '1) conflict_d = conflict_q + 1'b1;
        if (any) begin
            if (bus.lock[win] && win == ptr_q &&
                burst_cnt_q < BW'(max_burst - 1)) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else if (bus.lock[win] && win != ptr_q && max_burst > 1) begin
                // A locked core taking over starts its burst already counted.
                ptr_d       = win;
                burst_cnt_d = BW'(1);
            end else begin
                ptr_d       = nxt;
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            burst_cnt_q <= '0;
            rd_pend_q   <= '0;
            conflict_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            conflict_q  <= conflict_d;
        end
    end

    assign bus.gnt            = gnt;
    assign bus.rvalid         = rd_pend_q;
    assign bus.rdata          = bus.mem_q;
    assign bus.mem_addr       = mem_addr;
    assign bus.mem_wdata      = mem_wdata;
    assign bus.mem_wren       = any & bus.wr[win];
    assign bus.conflict_count = conflict_q;
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port, synchronous-read data RAM among `core_count` processor cores.
- Each core raises a request with address, write flag and write data. The arbiter grants one core per cycle and drives the RAM port from the winner.
- Read data comes back to the winning core one cycle later, tagged by a per-core valid.
- Optional per-core lock allows bounded back-to-back bursts. A saturating counter reports contention.
- Sits between the core array and the data memory, replacing the multiport RAM when area is constrained.

Parameters:
- `core_count`, 2, number of requesting cores (2..16)
- `addr_width`, 12, data memory address width
- `reg_width`, 12, data word width
- `max_burst`, 4, maximum consecutive grants to one locked core before forced rotation (>=1)
- `cnt_width`, 16, width of contention counter

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  core_count  per-core request, held until granted
- `lock`  in  core_count  per-core burst-lock hint, sampled with req
- `wr`  in  core_count  per-core write flag (1=write, 0=read)
- `addr_in`  in  addr_width*core_count  packed addresses; core j in bits [(j+1)*addr_width-1 -: addr_width]
- `wdata_in`  in  reg_width*core_count  packed write data; same packing as addr_in
- `gnt`  out  core_count  one-hot grant, combinational, same cycle as accepted request
- `rvalid`  out  core_count  one-hot; read data valid for that core this cycle
- `rdata`  out  reg_width  read data (= mem_q)
- `mem_addr`  out  addr_width  RAM address
- `mem_wdata`  out  reg_width  RAM write data
- `mem_wren`  out  1  RAM write enable
- `mem_q`  in  reg_width  RAM read data, valid one cycle after address presented
- `conflict_count`  out  cnt_width  saturating count of cycles with >=2 requests

Behaviour:
- State: `ptr` (priority pointer, 0..core_count-1), `burst_cnt` (0..max_burst-1), `rd_pend` (core_count-bit registered rvalid), `conflict_count`.
- Reset (`reset`=1 at clock edge): ptr=0, burst_cnt=0, rd_pend=0, conflict_count=0.
- While reset is high, `gnt`=0 and `mem_wren`=0 combinationally. `rvalid`=0 in the cycle after reset is sampled.
- Arbitration, combinational:
  - Winner k is the first requesting core scanning ptr, ptr+1, ... modulo core_count.
  - gnt[k]=1 only; all zeros if req=0.
- RAM drive:
  - mem_addr = addr_in slice k, mem_wdata = wdata_in slice k, mem_wren = gnt[k] & wr[k].
  - With no grant: mem_addr and mem_wdata hold slice of core ptr, mem_wren=0.
- Read return:
  - rd_pend <= gnt & ~wr each cycle, so rvalid = rd_pend and is exactly one cycle after the read grant.
  - rdata = mem_q unconditionally.
  - Writes complete at the grant edge; no rvalid is produced for a write.
- Pointer update on a grant to k:
  - If lock[k]=1, ptr==k and burst_cnt<max_burst-1: ptr stays k, burst_cnt+1.
  - Else if lock[k]=1 and ptr!=k: ptr<=k, burst_cnt<=1 if max_burst>1, else ptr<=(k+1) mod core_count and burst_cnt<=0.
  - Else: ptr<=(k+1) mod core_count, burst_cnt<=0.
- No grant: ptr and burst_cnt unchanged.
- Starvation bound: any held request is granted within (core_count-1)*max_burst+1 cycles.
- Contention counter: increments when popcount(req)>=2; saturates at all-ones, no wrap.
- Requester rule: req, wr, addr_in and wdata_in must stay stable until the cycle gnt is seen. Deasserting req before grant withdraws the request with no side effect.
- A core may re-request in the cycle after its grant. It then competes normally at the updated ptr.
- Reset mid-read: a grant issued the same cycle reset rises is suppressed, and no rvalid follows.

Test Plan:
- Single core 0 read of addr 0x005 holding 0xABC, no contention -> gnt=01 same cycle; rvalid=01 and rdata=0xABC next cycle; conflict_count stays 0.
- Both cores request reads every cycle, no lock, from reset -> gnt sequence 01,10,01,10; conflict_count=4 after 4 cycles.
- Core 1 writes 0x123 to 0x010, then core 0 reads 0x010 -> mem_wren=1 for one cycle only; core 0 gets rvalid=01, rdata=0x123; no rvalid for the write.
- Both cores request continuously, lock[0]=1, max_burst=4 -> core 0 granted 4 consecutive cycles, then core 1 granted once, then core 0 burst resumes.
- Continuous dual requests for 2^16+10 cycles with cnt_width=16 -> conflict_count saturates at 0xFFFF.
- Reset asserted in the cycle a read is granted -> gnt=0 and mem_wren=0 that cycle; rvalid=0 next; ptr=0 afterwards, so core 0 wins the next contended cycle.
